soc_event_sched: RTL



---
 rtl/soc_event_sched_pkg.sv | 16 +
 rtl/soc_event_sched_if.sv | 28 ++
 rtl/soc_event_sched_rr_arbiter.sv | 29 ++
 rtl/soc_event_sched.sv | 104 ++++++++++
 4 files changed

// File: rtl/soc_event_sched_pkg.sv
// Shared types, reset constant and pointer helper for the SoC event scheduler.
package soc_event_sched_pkg;

    typedef enum logic {
        SCHED_IDLE    = 1'b0,
        SCHED_PRESENT = 1'b1
    } sched_state_e;

    localparam int unsigned RR_RESET = 32'd0;

    // Wrapped increment of the round-robin pointer for a bank of n sources.
    function automatic int unsigned rr_wrap_inc(input int unsigned ptr, input int unsigned n);
        return ((ptr + 32'd1) >= n) ? 32'd0 : (ptr + 32'd1);
    endfunction

endpackage

// File: rtl/soc_event_sched_if.sv
// Event-queue bank / consumer channel / error signals of soc_event_sched.
interface soc_event_sched_if #(
    parameter int NB_EVENTS = 8
);
    localparam int ID_WIDTH = $clog2(NB_EVENTS);

    logic [NB_EVENTS-1:0] req_i;
    logic [NB_EVENTS-1:0] en_i;
    logic [NB_EVENTS-1:0] ack_o;
    logic                 evt_valid_o;
    logic [ID_WIDTH-1:0]  evt_id_o;
    logic                 evt_ready_i;
    logic [NB_EVENTS-1:0] err_i;
    logic [NB_EVENTS-1:0] err_status_o;
    logic [NB_EVENTS-1:0] err_clr_i;
    logic                 err_irq_o;

    modport master (
        output req_i, en_i, evt_ready_i, err_i, err_clr_i,
        input  ack_o, evt_valid_o, evt_id_o, err_status_o, err_irq_o
    );

    modport slave (
        input  req_i, en_i, evt_ready_i, err_i, err_clr_i,
        output ack_o, evt_valid_o, evt_id_o, err_status_o, err_irq_o
    );

endinterface

// File: rtl/soc_event_sched_rr_arbiter.sv
// Combinational round-robin search: first set candidate at or above i_ptr, wrapping.
module soc_event_rr_arbiter #(
    parameter  int N  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_cand,
    input  logic [IW-1:0] i_ptr,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    int w_sum;
    int w_pos;

    // Walk offsets from farthest to nearest so the nearest candidate is written last.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_sum   = 0;
        w_pos   = 0;
        for (int i = N - 1; i >= 0; i--) begin
            w_sum   = int'(i_ptr) + i;
            w_pos   = (w_sum >= N) ? (w_sum - N) : w_sum;
            o_found = o_found | i_cand[w_pos[IW-1:0]];
            o_idx   = i_cand[w_pos[IW-1:0]] ? w_pos[IW-1:0] : o_idx;
        end
    end

endmodule

// File: rtl/soc_event_sched.sv
// Round-robin event scheduler with overflow-error aggregation.
// Optional sticky error log enabled by defining SOC_EVENT_SCHED_ERR_LOG_EN.
module soc_event_sched
    import soc_event_sched_pkg::*;
#(
    parameter int NB_EVENTS = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    soc_event_sched_if.slave  bus
);

    localparam int ID_WIDTH = $clog2(NB_EVENTS);

    sched_state_e          r_state;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ID_WIDTH-1:0]   r_rr;
    logic                  r_err_irq;
    logic                  w_found;
    logic [ID_WIDTH-1:0]   w_idx;
    logic                  w_hs;
    logic [NB_EVENTS-1:0]  w_ack;

    soc_event_rr_arbiter #(.N(NB_EVENTS)) u_arb (
        .i_cand  (bus.req_i & bus.en_i),
        .i_ptr   (r_rr),
        .o_found (w_found),
        .o_idx   (w_idx)
    );

    assign w_hs = (r_state == SCHED_PRESENT) && bus.evt_ready_i;

    // Grant/present FSM; returning through IDLE lets the acked queue's req settle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= SCHED_IDLE;
            r_id    <= '0;
            r_rr    <= ID_WIDTH'(RR_RESET);
        end else begin
            case (r_state)
                SCHED_IDLE: begin
                    if (w_found) begin
                        r_id    <= w_idx;
                        r_state <= SCHED_PRESENT;
                    end
                end
                SCHED_PRESENT: begin
                    if (bus.evt_ready_i) begin
                        r_rr    <= ID_WIDTH'(rr_wrap_inc(32'(r_id), NB_EVENTS));
                        r_state <= SCHED_IDLE;
                    end
                end
                default: r_state <= SCHED_IDLE;
            endcase
        end
    end

    // One-hot acknowledge to the presented source during the handshake only.
    always_comb begin
        w_ack = '0;
        if (w_hs) begin
            w_ack[r_id] = 1'b1;
        end else begin
            w_ack = '0;
        end
    end

`ifdef SOC_EVENT_SCHED_ERR_LOG_EN
    logic [NB_EVENTS-1:0] r_err_status;

    // Sticky per-queue error flags (set beats clear); irq follows the flags one cycle later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err_status <= '0;
            r_err_irq    <= 1'b0;
        end else begin
            r_err_status <= (r_err_status & ~bus.err_clr_i) | bus.err_i;
            r_err_irq    <= |r_err_status;
        end
    end

    assign bus.err_status_o = r_err_status;
`else
    logic w_unused_clr;

    // Without the log the interrupt is a registered pulse per overflow event.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err_irq <= 1'b0;
        end else begin
            r_err_irq <= |bus.err_i;
        end
    end

    assign bus.err_status_o = '0;
    assign w_unused_clr     = ^bus.err_clr_i;
`endif

    assign bus.evt_valid_o = (r_state == SCHED_PRESENT);
    assign bus.evt_id_o    = r_id;
    assign bus.ack_o       = w_ack;
    assign bus.err_irq_o   = r_err_irq;

endmodule
